// File: rtl/mul_seq_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mul_seq_ctrl_if : request/result bundle of the shift-add multiplier |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface mul_seq_ctrl_if #(
  parameter int WIDTH = 24
);
  logic               start;
  logic               is_signed;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               abort;
  logic               ready;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (
    output start, is_signed, a, b, abort,
    input  ready, busy, done, product
  );

  modport slave (
    input  start, is_signed, a, b, abort,
    output ready, busy, done, product
  );
endinterface
`default_nettype wire

// File: rtl/mul_seq_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mul_seq_ctrl : fixed-latency sequential shift-add multiplier ctrl  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module mul_seq_ctrl #(
  parameter int WIDTH = 24,
  parameter int CNT_W = 5
) (
  input  wire           clk_i,
  input  wire           rst_i,
  mul_seq_ctrl_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state_q,   state_d;
  logic [2*WIDTH-1:0] mcand_q,   mcand_d;
  logic [WIDTH-1:0]   mplier_q,  mplier_d;
  logic [2*WIDTH-1:0] acc_q,     acc_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic               neg_q,     neg_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic               accept;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] acc_next;

  assign bus.ready   = (state_q != S_RUN);
  assign bus.busy    = (state_q == S_RUN);
  assign bus.done    = (state_q == S_DONE);
  assign bus.product = product_q;

  assign accept = bus.start && bus.ready;

  // -2**(W-1) negates to itself, which read as unsigned is the correct magnitude.
  assign a_mag = (bus.is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign b_mag = (bus.is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  // mcand_q is pre-shifted each cycle, so it always equals the original mcand << cnt.
  assign acc_next = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    product_d = product_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          state_d  = S_RUN;
          mcand_d  = {{WIDTH{1'b0}}, a_mag};
          mplier_d = b_mag;
          neg_d    = bus.is_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else begin
          acc_d    = acc_next;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            product_d = neg_q ? -acc_next : acc_next;
            state_d   = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      product_q <= product_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mul_seq_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mul_seq_ctrl : directed + randomized bench, arithmetic ref model |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_mul_seq_ctrl;

  localparam int WIDTH = 24;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  mul_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

  mul_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(5)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer multiply of the operands as the caller means them.
  function automatic logic [47:0] ref_mul(input logic [23:0] a, input logic [23:0] b, input logic s);
    longint x;
    longint y;
    if (s) begin
      x = $signed(a);
      y = $signed(b);
    end else begin
      x = {40'd0, a};
      y = {40'd0, b};
    end
    return 48'(x * y);
  endfunction

  function automatic logic [23:0] pick_operand();
    case ($urandom_range(0, 9))
      0:       return 24'h000000;
      1:       return 24'h000001;
      2:       return 24'hFFFFFF;
      3:       return 24'h800000;
      4:       return 24'h7FFFFF;
      default: return 24'($urandom);
    endcase
  endfunction

  // Presents a request in the cycle before an edge; returns just after the accepting edge.
  task automatic start_op(input logic [23:0] a, input logic [23:0] b, input logic s, input logic ab);
    @(negedge clk);
    chk_eq("ready_at_request", 64'(bus.ready), 64'd1);
    bus.start     = 1'b1;
    bus.a         = a;
    bus.b         = b;
    bus.is_signed = s;
    bus.abort     = ab;
    @(posedge clk);
    #1;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.a         = 24'($urandom);
    bus.b         = 24'($urandom);
    bus.is_signed = 1'($urandom);
  endtask

  // Called just after an accepting edge; the request cycle counts as cycle 0.
  task automatic wait_done(input string tag, input logic [47:0] exp, input logic noise);
    int          cyc;
    int          busy_cnt;
    logic        seen;
    logic        stable;
    logic [47:0] held;
    cyc      = 0;
    busy_cnt = 0;
    seen     = 1'b0;
    stable   = 1'b1;
    held     = bus.product;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus.done) begin
        seen = 1'b1;
        chk_eq({tag, "_ready_in_done"}, 64'(bus.ready), 64'd1);
        chk_eq({tag, "_busy_in_done"}, 64'(bus.busy), 64'd0);
      end else begin
        if (bus.busy) busy_cnt++;
        if (bus.product !== held) stable = 1'b0;
        if (noise) bus.start = (cyc < 20) ? 1'($urandom) : 1'b0;
      end
    end
    chk_eq({tag, "_latency"}, 64'(cyc), 64'd25);
    chk_eq({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd24);
    chk_eq({tag, "_product_held"}, 64'(stable), 64'd1);
    chk_eq({tag, "_product"}, 64'(bus.product), 64'(exp));
  endtask

  initial begin
    logic [23:0] ra;
    logic [23:0] rb;
    logic        rs;
    int          done_cnt;

    n_checks      = 0;
    n_errors      = 0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.abort     = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk_eq("rst_ready", 64'(bus.ready), 64'd1);
    chk_eq("rst_busy", 64'(bus.busy), 64'd0);
    chk_eq("rst_done", 64'(bus.done), 64'd0);
    chk_eq("rst_product", 64'(bus.product), 64'd0);

    start_op(24'd3, 24'd5, 1'b0, 1'b0);
    wait_done("u3x5", 48'd15, 1'b0);
    @(negedge clk);
    chk_eq("done_one_cycle", 64'(bus.done), 64'd0);
    chk_eq("idle_after_done", 64'({bus.ready, bus.busy}), 64'b10);

    start_op(24'hFFFFFF, 24'hFFFFFF, 1'b0, 1'b0);
    wait_done("umax", 48'hFFFFFE000001, 1'b1);

    start_op(24'hFFFFFF, 24'd7, 1'b1, 1'b0);
    wait_done("sm1x7", 48'hFFFFFFFFFFF9, 1'b1);

    start_op(24'h800000, 24'h800000, 1'b1, 1'b0);
    wait_done("smin_sq", 48'h400000000000, 1'b1);

    // Start held high across a whole operation: the second request lands on the DONE cycle.
    @(negedge clk);
    bus.start     = 1'b1;
    bus.a         = 24'd6;
    bus.b         = 24'd7;
    bus.is_signed = 1'b0;
    @(posedge clk);
    #1;
    bus.a = 24'd2;
    bus.b = 24'd2;
    wait_done("b2b_6x7", 48'd42, 1'b0);
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done("b2b_2x2", 48'd4, 1'b0);

    start_op(24'd6, 24'd7, 1'b0, 1'b0);
    wait_done("pre_abort", 48'd42, 1'b0);
    start_op(24'd123, 24'd456, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    bus.abort = 1'b1;
    @(posedge clk);
    #1 bus.abort = 1'b0;
    @(negedge clk);
    chk_eq("abort_idle", 64'({bus.ready, bus.busy, bus.done}), 64'b100);
    chk_eq("abort_product", 64'(bus.product), 64'd42);
    done_cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    chk_eq("abort_no_done", 64'(done_cnt), 64'd0);
    start_op(24'd9, 24'd9, 1'b0, 1'b0);
    wait_done("post_abort_9x9", 48'd81, 1'b0);

    start_op(24'd11, 24'd13, 1'b0, 1'b1);
    wait_done("abort_with_start", 48'd143, 1'b0);

    start_op(24'd1000, 24'd1000, 1'b0, 1'b0);
    repeat (12) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_eq("midrst_flags", 64'({bus.ready, bus.busy, bus.done}), 64'b100);
    chk_eq("midrst_product", 64'(bus.product), 64'd0);

    start_op(24'hFFFFFB, 24'd0, 1'b1, 1'b0);
    wait_done("signed_zero", 48'd0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      ra = pick_operand();
      rb = pick_operand();
      rs = 1'($urandom);
      start_op(ra, rb, rs, 1'b0);
      wait_done($sformatf("rand%0d", i), ref_mul(ra, rb, rs), 1'b1);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
